// File: rtl/forward_activation_pkg.sv
// Shared network helpers: accumulator width and the ReLU/saturating clip used by
// every activation stage (hidden and output layers).
package forward_activation_pkg;

    typedef struct packed {
        logic        deriv;
        logic [63:0] state;
    } actResult_t;

    function automatic int accWidth(input int np, input int wv);
        return $clog2(np) + wv;
    endfunction

    // Caller sign-extends the lane sum to 64 bits and keeps state[wv-1:0].
    function automatic actResult_t activate(input logic signed [63:0] accum,
                                            input int sh, input int wv);
        logic signed [63:0] s;
        logic signed [63:0] maxVal;
        actResult_t         r;
        s       = accum >>> sh;
        maxVal  = (64'sd1 <<< (wv - 1)) - 64'sd1;
        r.deriv = (s > 64'sd0);
        if (s <= 64'sd0)
            r.state = '0;
        else if (s > maxVal)
            r.state = maxVal;
        else
            r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/forward_activation_fork.sv
// Generic one-deep register feeding two independently draining output branches.
module fork_reg #(
    parameter int    W0    = 16,
    parameter int    W1    = 2,
    parameter string BURST = "yes"
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iValid,
    output logic          oReady,
    input  logic [W0-1:0] iData0,
    input  logic [W1-1:0] iData1,
    output logic          oValid0,
    input  logic          iReady0,
    output logic [W0-1:0] oData0,
    output logic          oValid1,
    input  logic          iReady1,
    output logic [W1-1:0] oData1
);

    logic full0, full1, canAccept, accept;

    generate
        if (BURST == "yes") begin : gBurst
            assign canAccept = (!full0 || iReady0) && (!full1 || iReady1);
        end else begin : gSingle
            assign canAccept = !full0 && !full1;
        end
    endgenerate

    // Gate with reset so the producer sees not-ready for the whole reset window.
    assign oReady  = iRST && canAccept;
    assign accept  = iValid && oReady;
    assign oValid0 = full0;
    assign oValid1 = full1;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            full0  <= 1'b0;
            full1  <= 1'b0;
            oData0 <= '0;
            oData1 <= '0;
        end else if (accept) begin
            full0  <= 1'b1;
            full1  <= 1'b1;
            oData0 <= iData0;
            oData1 <= iData1;
        end else begin
            if (iReady0) full0 <= 1'b0;
            if (iReady1) full1 <= 1'b0;
        end
    end

endmodule

// File: rtl/forward_activation_lane.sv
// One neuron lane: shift, ReLU, saturate and derivative bit, purely combinational.
module activation_lane
    import forward_activation_pkg::*;
#(
    parameter int WA = 10,
    parameter int WV = 8,
    parameter int SH = 0
) (
    input  logic signed [WA-1:0] accum,
    output logic        [WV-1:0] state,
    output logic                 deriv
);

    actResult_t r;
    logic       unusedHi;

    assign r        = activate(64'(accum), SH, WV);
    assign state    = r.state[WV-1:0];
    assign deriv    = r.deriv;
    assign unusedHi = ^r.state[63:WV];

endmodule

// File: rtl/forward_activation.sv
// Forward activation stage: per-lane ReLU/clip of accumulator sums, forked to the
// next layer (state) and the backward path (derivative mask).
module forward_activation
    import forward_activation_pkg::*;
#(
    parameter int    NP    = 3,
    parameter int    NC    = 2,
    parameter int    WV    = 8,
    parameter int    SH    = 0,
    parameter string BURST = "yes",
    localparam int   WA    = accWidth(NP, WV)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AM_Accum,
    output logic             oReady_AM_Accum,
    input  logic [NC*WA-1:0] iData_AM_Accum,
    output logic             oValid_BM_State,
    input  logic             iReady_BM_State,
    output logic [NC*WV-1:0] oData_BM_State,
    output logic             oValid_BM_Deriv,
    input  logic             iReady_BM_Deriv,
    output logic [NC-1:0]    oData_BM_Deriv
);

    logic [NC-1:0][WV-1:0] laneState;
    logic [NC-1:0]         laneDeriv;

    generate
        for (genvar k = 0; k < NC; k++) begin : gLane
            activation_lane #(.WA(WA), .WV(WV), .SH(SH)) uLane (
                .accum (iData_AM_Accum[k*WA +: WA]),
                .state (laneState[k]),
                .deriv (laneDeriv[k])
            );
        end
    endgenerate

    fork_reg #(.W0(NC*WV), .W1(NC), .BURST(BURST)) uFork (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iValid  (iValid_AM_Accum),
        .oReady  (oReady_AM_Accum),
        .iData0  (laneState),
        .iData1  (laneDeriv),
        .oValid0 (oValid_BM_State),
        .iReady0 (iReady_BM_State),
        .oData0  (oData_BM_State),
        .oValid1 (oValid_BM_Deriv),
        .iReady1 (iReady_BM_Deriv),
        .oData1  (oData_BM_Deriv)
    );

endmodule

// File: tb/tb_forward_activation.sv
// Scoreboard bench: u0 is BURST="yes"/SH=0, u1 is BURST="no"/SH=2.
module tb_forward_activation;

    localparam int WA = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        v   [2];
    logic [19:0] d   [2];
    logic        rdy [2];
    logic        vS  [2];
    logic        rS  [2];
    logic [15:0] dS  [2];
    logic        vD  [2];
    logic        rD  [2];
    logic [1:0]  dD  [2];

    logic [15:0] qS0[$], qS1[$];
    logic [1:0]  qD0[$], qD1[$];
    int          nChecks = 0, nPass = 0, cyc = 0;
    int          lastAcc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    forward_activation #(.NP(3), .NC(2), .WV(8), .SH(0), .BURST("yes")) u0 (
        .iCLK(clk), .iRST(rst),
        .iValid_AM_Accum(v[0]), .oReady_AM_Accum(rdy[0]), .iData_AM_Accum(d[0]),
        .oValid_BM_State(vS[0]), .iReady_BM_State(rS[0]), .oData_BM_State(dS[0]),
        .oValid_BM_Deriv(vD[0]), .iReady_BM_Deriv(rD[0]), .oData_BM_Deriv(dD[0]));

    forward_activation #(.NP(3), .NC(2), .WV(8), .SH(2), .BURST("no")) u1 (
        .iCLK(clk), .iRST(rst),
        .iValid_AM_Accum(v[1]), .oReady_AM_Accum(rdy[1]), .iData_AM_Accum(d[1]),
        .oValid_BM_State(vS[1]), .iReady_BM_State(rS[1]), .oData_BM_State(dS[1]),
        .oValid_BM_Deriv(vD[1]), .iReady_BM_Deriv(rD[1]), .oData_BM_Deriv(dD[1]));

    task automatic chk(input string tag, input longint obs, input longint exp);
        nChecks++;
        if (obs == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [7:0] expS(input int a, input int sh);
        int s;
        s = a >>> sh;
        if (s <= 0) return 8'd0;
        if (s > 127) return 8'd127;
        return 8'(s);
    endfunction

    function automatic logic expD(input int a, input int sh);
        return (a >>> sh) > 0;
    endfunction

    // Output monitors: every handshake pops one expected word.
    always @(negedge clk) begin
        if (rst) begin
            if (vS[0] && rS[0]) begin
                if (qS0.size() == 0) chk("state0Extra", 1, 0);
                else chk("state0", dS[0], qS0.pop_front());
            end
            if (vD[0] && rD[0]) begin
                if (qD0.size() == 0) chk("deriv0Extra", 1, 0);
                else chk("deriv0", dD[0], qD0.pop_front());
            end
            if (vS[1] && rS[1]) begin
                if (qS1.size() == 0) chk("state1Extra", 1, 0);
                else chk("state1", dS[1], qS1.pop_front());
            end
            if (vD[1] && rD[1]) begin
                if (qD1.size() == 0) chk("deriv1Extra", 1, 0);
                else chk("deriv1", dD[1], qD1.pop_front());
            end
        end
    end

    // Drive one word and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input int idx, input int a0, input int a1);
        int  sh;
        bit  acc;
        sh       = (idx == 1) ? 2 : 0;
        v[idx]   = 1'b1;
        d[idx]   = {10'(a1), 10'(a0)};
        if (idx == 0) begin
            qS0.push_back({expS(a1, sh), expS(a0, sh)});
            qD0.push_back({expD(a1, sh), expD(a0, sh)});
        end else begin
            qS1.push_back({expS(a1, sh), expS(a0, sh)});
            qD1.push_back({expD(a1, sh), expD(a0, sh)});
        end
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = rdy[idx];
            @(posedge clk);
            #1;
        end
        if (!acc) chk("acceptTimeout", 0, 1);
        else lastAcc[idx] = cyc;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 50; i++) begin
            if (qS0.size() + qD0.size() + qS1.size() + qD1.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drained", qS0.size() + qD0.size() + qS1.size() + qD1.size(), 0);
    endtask

    initial begin
        int firstAcc;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; d[i] = '0; rS[i] = 1'b1; rD[i] = 1'b1;
        end
        #3 rst = 1'b0;
        #2;
        chk("rstReady", rdy[0], 0);
        chk("rstValidS", vS[0], 0);
        chk("rstValidD", vD[0], 0);
        chk("rstDataS", dS[0], 0);
        chk("rstDataD", dD[0], 0);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("readyAfterRst0", rdy[0], 1);
        chk("readyAfterRst1", rdy[1], 1);

        // Basic lanes, latency 1, one-cycle valid
        send(0, 100, 50);
        chk("latValidS", vS[0], 1);
        chk("latValidD", vD[0], 1);
        v[0] = 1'b0;
        @(posedge clk); #1;
        chk("validDropS", vS[0], 0);
        chk("validDropD", vD[0], 0);

        // Negative/zero and saturation
        send(0, -5, 0);
        send(0, 300, -512);
        v[0] = 1'b0;
        send(1, 300, 8);
        v[1] = 1'b0;
        waitDrain();

        // Deriv branch stalled for 5 cycles
        rD[0] = 1'b0;
        send(0, 20, -3);
        v[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stallReady", rdy[0], 0);
            chk("stallDerivData", dD[0], 2'b01);
            chk("stallDerivValid", vD[0], 1);
            @(posedge clk); #1;
        end
        chk("stateDrained", vS[0], 0);
        rD[0] = 1'b1;
        waitDrain();

        // Throughput: one word/cycle in burst mode, one per two cycles otherwise
        for (int k = 0; k < 6; k++) begin
            send(0, k * 10 + 1, 7 - k);
            if (k == 0) firstAcc = lastAcc[0];
        end
        v[0] = 1'b0;
        chk("burstYesSpan", lastAcc[0] - firstAcc, 5);
        for (int k = 0; k < 6; k++) begin
            send(1, k * 40 + 8, -k);
            if (k == 0) firstAcc = lastAcc[1];
        end
        v[1] = 1'b0;
        chk("burstNoSpan", lastAcc[1] - firstAcc, 10);
        waitDrain();

        // Reset while both branches full: old word must vanish
        rS[0] = 1'b0; rD[0] = 1'b0;
        send(0, 60, 70);
        v[0] = 1'b0;
        chk("fullBeforeRstS", vS[0], 1);
        rst = 1'b0;
        #1;
        chk("midRstValidS", vS[0], 0);
        chk("midRstValidD", vD[0], 0);
        chk("midRstReady", rdy[0], 0);
        qS0.delete(); qD0.delete();
        @(posedge clk); #1;
        rst = 1'b1; rS[0] = 1'b1; rD[0] = 1'b1;
        send(0, 33, 44);
        v[0] = 1'b0;
        waitDrain();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/forward_activation.md
FORWARD_ACTIVATION -- requirements
Module: forward_activation

Interface
REQ-001 SHALL have parameter NP, default 3: number of previous-layer neurons; sets accumulator growth $clog2(NP).
REQ-002 SHALL have parameter NC, default 2: number of current-layer neurons (lanes).
REQ-003 SHALL have parameter WV, default 8: signed state width.
REQ-004 SHALL have parameter SH, default 0: arithmetic right shift applied before clipping.
REQ-005 SHALL have parameter BURST, default "yes": "yes" = full throughput; "no" = accept only when both output branches are empty.
REQ-006 SHALL have port iCLK, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port iRST, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port iValid_AM_Accum, input, 1 bit: accumulator word valid.
REQ-009 SHALL have port oReady_AM_Accum, output, 1 bit: accumulator word accepted.
REQ-010 SHALL have port iData_AM_Accum, input, NC*WA bits, WA=$clog2(NP)+WV: signed lane sums; lane k at [k*WA+:WA].
REQ-011 SHALL have port oValid_BM_State, output, 1 bit: activated state valid.
REQ-012 SHALL have port iReady_BM_State, input, 1 bit: next layer ready.
REQ-013 SHALL have port oData_BM_State, output, NC*WV bits: activated lanes; lane k at [k*WV+:WV].
REQ-014 SHALL have port oValid_BM_Deriv, output, 1 bit: derivative mask valid.
REQ-015 SHALL have port iReady_BM_Deriv, input, 1 bit: backward path ready.
REQ-016 SHALL have port oData_BM_Deriv, output, NC bits: bit k = ReLU derivative of lane k.

Function
REQ-017 SHALL transfer on the input when iValid_AM_Accum and oReady_AM_Accum are both 1 at a rising edge; outputs likewise with their valid/ready pairs.
REQ-018 SHALL compute per lane: s = accum >>> SH (arithmetic); state = 0 if s<=0; 2^(WV-1)-1 if s>2^(WV-1)-1; else s[WV-1:0].
REQ-019 SHALL set deriv bit k = 1 iff s>0, saturated lanes included.
REQ-020 SHALL register both results on the accepting edge, so both output valids rise one cycle after the input transfer (latency 1).
REQ-021 SHALL keep one FULL/EMPTY flag per output branch: EMPTY->FULL on input accept; FULL->EMPTY on its own handshake without a simultaneous accept; FULL stays FULL when handshake and accept coincide.
REQ-022 SHALL, with BURST="yes", drive oReady_AM_Accum = (State EMPTY or iReady_BM_State) and (Deriv EMPTY or iReady_BM_Deriv).
REQ-023 SHALL, with BURST="no", drive oReady_AM_Accum = State EMPTY and Deriv EMPTY.
REQ-024 SHALL drain the branches independently; a drained branch stays EMPTY, with its data held, until the other branch drains and a new word is accepted.
REQ-025 SHALL hold oData_BM_State and oData_BM_Deriv stable while the corresponding valid is 1 and ready is 0.
REQ-026 SHALL never drop or duplicate a word: each accepted input produces exactly one State transfer and one Deriv transfer.

Reset
REQ-027 SHALL, when iRST is 0, asynchronously clear both flags to EMPTY and force oValid_BM_State=0, oValid_BM_Deriv=0, oData_BM_State=0, oData_BM_Deriv=0.
REQ-028 SHALL drive oReady_AM_Accum=0 while iRST is 0 and 1 on the first cycle after release.
REQ-029 SHALL discard a word pending in either branch when reset is asserted mid-operation; no stale transfer occurs after release.

Structure
REQ-030 SHALL place the activation clip function (shift, ReLU, saturation, derivative) and the WA width expression in the shared network package, for reuse by the output layer.
REQ-031 SHALL instantiate NC copies of a single combinational sub-module activation_lane, plus one generic two-branch fork register.

Verification (NP=3, NC=2, WV=8, SH=0, WA=10)
REQ-032 SHALL cover: lanes {100, 50}, both readies 1 -> next cycle State {100, 50}, Deriv 2'b11, valids high for one cycle.
REQ-033 SHALL cover: lanes {-5, 0} -> State {0, 0}, Deriv 2'b00.
REQ-034 SHALL cover: lanes {300, -512} -> State {127, 0}, Deriv 2'b01; with SH=2, lanes {300, 8} -> State {75, 2}, Deriv 2'b11.
REQ-035 SHALL cover: iReady_BM_Deriv held 0 for 5 cycles, State ready 1 -> State transfers once, oReady_AM_Accum stays 0, Deriv data stable, accepted exactly once on release.
REQ-036 SHALL cover: back-to-back inputs, BURST="yes", both readies 1 -> one word per cycle; BURST="no" -> one word every 2 cycles.
REQ-037 SHALL cover: iRST pulsed low while both branches are FULL -> valids 0 immediately; after release the first output equals the next input, not the old word.
